// File: rtl/host_cmd_arb.sv
// N-master host command arbiter: round-robin merge onto one slave port, in-order
// read-response routing through an ownership FIFO, and read-timeout error retirement.
module host_cmd_arb #(
   parameter int unsigned NUM_MST   = 4,
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned MAX_OUTST = 4,
   parameter int unsigned TIMEOUT   = 255
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_MST-1:0]        m_cmd_vld,
   output logic [NUM_MST-1:0]        m_cmd_rdy,
   input  logic [NUM_MST*ADDR_W-1:0] m_addr,
   input  logic [NUM_MST*DATA_W-1:0] m_data_w,
   input  logic [NUM_MST-1:0]        m_rw,
   output logic [DATA_W-1:0]         m_data_r,
   output logic [NUM_MST-1:0]        m_rd_vld,
   output logic [NUM_MST-1:0]        m_rd_err,
   output logic                      s_cmd_vld,
   input  logic                      s_cmd_rdy,
   output logic [ADDR_W-1:0]         s_addr,
   output logic [DATA_W-1:0]         s_data_w,
   output logic                      s_rw,
   input  logic [DATA_W-1:0]         s_data_r,
   input  logic                      s_rd_vld,
   output logic                      stray_rsp
);
   localparam int unsigned IDX_W = $clog2(NUM_MST);
   localparam int unsigned PTR_W = $clog2(MAX_OUTST);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTST);
   localparam logic [15:0]      TO_LIM   = 16'(TIMEOUT);

   logic [IDX_W-1:0]  rr_q, rr_d, win;
   logic [IDX_W:0]    cand;
   logic [NUM_MST-1:0] elig;
   logic              any_elig, loadable, grant;

   logic              ocr_vld_q, ocr_rw_q;
   logic [ADDR_W-1:0] ocr_addr_q;
   logic [DATA_W-1:0] ocr_data_q;

   logic [IDX_W-1:0]  own_mem [MAX_OUTST];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [IDX_W-1:0]  head;
   logic              push, pop_rsp, to_hit, pop;

   logic [15:0]       to_q, to_d;

   logic [NUM_MST-1:0] rd_vld_q, rd_err_q;
   logic [DATA_W-1:0]  data_r_q;
   logic               stray_q;

   // Reads are held off while the registered count shows the FIFO full.
   always_comb begin
      for (int unsigned i = 0; i < NUM_MST; i++) begin
         elig[i] = m_cmd_vld[i] & (m_rw[i] | (cnt_q != FULL_CNT));
      end
   end

   // rr_q names the highest-priority master; search upward from it with wraparound.
   always_comb begin
      any_elig = 1'b0;
      win      = '0;
      cand     = '0;
      for (int unsigned k = 0; k < NUM_MST; k++) begin
         cand = {1'b0, rr_q} + (IDX_W+1)'(k);
         if (cand >= (IDX_W+1)'(NUM_MST)) begin
            cand = cand - (IDX_W+1)'(NUM_MST);
         end
         if (!any_elig && elig[cand[IDX_W-1:0]]) begin
            any_elig = 1'b1;
            win      = cand[IDX_W-1:0];
         end
      end
   end

   always_comb begin
      loadable  = ~ocr_vld_q | s_cmd_rdy;
      grant     = loadable & any_elig;
      m_cmd_rdy = '0;
      rr_d      = rr_q;
      if (grant) begin
         m_cmd_rdy[win] = 1'b1;
         rr_d = (win == IDX_W'(NUM_MST - 1)) ? '0 : win + 1'b1;
      end
   end

   always_comb begin
      head    = own_mem[rd_ptr_q];
      push    = grant & ~m_rw[win];
      pop_rsp = s_rd_vld & (cnt_q != '0);
      // A real response in the expiry cycle takes precedence over the error.
      to_hit  = (cnt_q != '0) & ~s_rd_vld & (to_q == TO_LIM);
      pop     = pop_rsp | to_hit;
      cnt_d   = cnt_q;
      if (push && !pop) begin
         cnt_d = cnt_q + 1'b1;
      end else if (!push && pop) begin
         cnt_d = cnt_q - 1'b1;
      end
      if ((cnt_q == '0) || s_rd_vld || to_hit) begin
         to_d = '0;
      end else begin
         to_d = to_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         own_mem[wr_ptr_q] <= win;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_q       <= '0;
         ocr_vld_q  <= 1'b0;
         ocr_rw_q   <= 1'b0;
         ocr_addr_q <= '0;
         ocr_data_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         to_q       <= '0;
         rd_vld_q   <= '0;
         rd_err_q   <= '0;
         data_r_q   <= '0;
         stray_q    <= 1'b0;
      end else begin
         rr_q     <= rr_d;
         cnt_q    <= cnt_d;
         to_q     <= to_d;
         rd_vld_q <= '0;
         rd_err_q <= '0;
         stray_q  <= s_rd_vld & (cnt_q == '0);
         if (grant) begin
            ocr_vld_q  <= 1'b1;
            ocr_rw_q   <= m_rw[win];
            ocr_addr_q <= m_addr[32'(win)*ADDR_W +: ADDR_W];
            ocr_data_q <= m_data_w[32'(win)*DATA_W +: DATA_W];
         end else if (s_cmd_rdy) begin
            ocr_vld_q <= 1'b0;
         end
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q       <= rd_ptr_q + 1'b1;
            rd_vld_q[head] <= 1'b1;
         end
         if (pop_rsp) begin
            data_r_q <= s_data_r;
         end else if (to_hit) begin
            data_r_q       <= '0;
            rd_err_q[head] <= 1'b1;
         end
      end
   end

   assign s_cmd_vld = ocr_vld_q;
   assign s_addr    = ocr_addr_q;
   assign s_data_w  = ocr_data_q;
   assign s_rw      = ocr_rw_q;
   assign m_rd_vld  = rd_vld_q;
   assign m_rd_err  = rd_err_q;
   assign m_data_r  = data_r_q;
   assign stray_rsp = stray_q;

endmodule
